// File: rtl/core_ifu_if.sv
// Fetch channel between core_ifu (master) and instruction memory (slave).
`timescale 1ns/1ps
interface core_ifu_if;
    // Request transfers when mem_req_valid_out && mem_req_ready_in at a clk edge; a raised valid
    // keeps its address until it transfers unless the IFU redirects. Responses return in request
    // order, at least one cycle after their request transferred, and cannot be back-pressured.
    logic        mem_req_valid_out;
    logic [31:0] mem_req_addr_out;
    logic        mem_req_ready_in;
    logic        mem_rsp_valid_in;
    logic [31:0] mem_rsp_data_in;

    modport master (
        output mem_req_valid_out,
        output mem_req_addr_out,
        input  mem_req_ready_in,
        input  mem_rsp_valid_in,
        input  mem_rsp_data_in
    );

    modport slave (
        input  mem_req_valid_out,
        input  mem_req_addr_out,
        output mem_req_ready_in,
        output mem_rsp_valid_in,
        output mem_rsp_data_in
    );
endinterface

// File: rtl/core_ifu.sv
// Instruction fetch unit: PC, credit-limited in-order fetch, prefetch FIFO, redirect drain.
// Define CORE_IFU_RSP_BYPASS_EN to forward a response into an empty FIFO straight to the outputs.
`timescale 1ns/1ps
module core_ifu #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    core_ifu_if.master  mem,
    input  logic        jump_en_in,
    input  logic [31:0] jump_addr_in,
    input  logic        hold_en_in,
    output logic        inst_valid_out,
    output logic [31:0] inst_out,
    output logic [31:0] inst_addr_out,
    output logic [1:0]  dbg_state_o
);
    localparam int          PW      = $clog2(FIFO_DEPTH);
    localparam int          CW      = 3;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] out_q, out_d, disc_q, disc_d, cnt_q, cnt_d;
    logic [PW-1:0] f_rd_q, f_rd_d, f_wr_q, f_wr_d, a_rd_q, a_rd_d, a_wr_q, a_wr_d;
    logic [31:0]   f_addr_q [FIFO_DEPTH];
    logic [31:0]   f_inst_q [FIFO_DEPTH];
    logic [31:0]   aq_q     [FIFO_DEPTH];

    logic        jump, req_hs, rsp_take, push, fifo_deq, byp_out, byp_deq, wr_fifo;
    logic [CW:0] used;

    assign jump     = jump_en_in && (state_q != BOOT);
    assign rsp_take = mem.mem_rsp_valid_in && (out_q != '0);
    assign push     = rsp_take && (state_q == RUN) && (disc_q == '0) && !jump;
    assign fifo_deq = (cnt_q != '0) && !hold_en_in;

    // The slot freed by this cycle's dequeue is already counted as credit, which keeps a
    // one-cycle memory streaming at one word per cycle with only two entries.
    assign used = {1'b0, out_q} + {1'b0, cnt_q} - {{CW{1'b0}}, fifo_deq};
    assign mem.mem_req_valid_out = (state_q == RUN) && (used < DEPTH_C);
    assign mem.mem_req_addr_out  = pc_q;
    assign req_hs = mem.mem_req_valid_out && mem.mem_req_ready_in;

`ifdef CORE_IFU_RSP_BYPASS_EN
    assign byp_out = push && (cnt_q == '0);
`else
    assign byp_out = 1'b0;
`endif
    assign byp_deq = byp_out && !hold_en_in;
    assign wr_fifo = push && !byp_deq;

    assign dbg_state_o = state_q;

    always_comb begin
        inst_valid_out = 1'b0;
        inst_out       = NOP;
        inst_addr_out  = '0;
        if (cnt_q != '0) begin
            inst_valid_out = 1'b1;
            inst_out       = f_inst_q[f_rd_q];
            inst_addr_out  = f_addr_q[f_rd_q];
        end else if (byp_out) begin
            inst_valid_out = 1'b1;
            inst_out       = mem.mem_rsp_data_in;
            inst_addr_out  = aq_q[a_rd_q];
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        disc_d  = disc_q;
        out_d   = out_q + CW'(req_hs) - CW'(rsp_take);
        cnt_d   = cnt_q + CW'(wr_fifo) - CW'(fifo_deq);
        f_rd_d  = f_rd_q + PW'(fifo_deq);
        f_wr_d  = f_wr_q + PW'(wr_fifo);
        a_rd_d  = a_rd_q + PW'(push);
        a_wr_d  = a_wr_q + PW'(req_hs);
        case (state_q)
            BOOT:  state_d = RUN;
            RUN:   if (req_hs) pc_d = pc_q + 32'd4;
            DRAIN: begin
                if (rsp_take && (disc_q != '0)) disc_d = disc_q - CW'(1);
                if (disc_d == '0) state_d = RUN;
            end
            default: state_d = BOOT;
        endcase
        // Everything still in flight after this edge belongs to the abandoned path.
        if (jump) begin
            pc_d    = {jump_addr_in[31:2], 2'b00};
            disc_d  = out_d;
            cnt_d   = '0;
            f_rd_d  = '0;
            f_wr_d  = '0;
            a_rd_d  = '0;
            a_wr_d  = '0;
            state_d = ((out_d != '0) || (state_q == DRAIN)) ? DRAIN : RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            out_q   <= '0;
            disc_q  <= '0;
            cnt_q   <= '0;
            f_rd_q  <= '0;
            f_wr_q  <= '0;
            a_rd_q  <= '0;
            a_wr_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
            disc_q  <= disc_d;
            cnt_q   <= cnt_d;
            f_rd_q  <= f_rd_d;
            f_wr_q  <= f_wr_d;
            a_rd_q  <= a_rd_d;
            a_wr_q  <= a_wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (req_hs) aq_q[a_wr_q] <= pc_q;
        if (wr_fifo) begin
            f_addr_q[f_wr_q] <= aq_q[a_rd_q];
            f_inst_q[f_wr_q] <= mem.mem_rsp_data_in;
        end
    end
endmodule

// File: tb/tb_core_ifu.sv
// Directed bench for core_ifu: in-order memory model, sequential-stream scoreboard, redirect table.
`timescale 1ns/1ps
module tb_core_ifu;
    localparam logic [31:0] K   = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef CORE_IFU_RSP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        hold_en;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic [1:0]  dbg_state;

    core_ifu_if mif();

    core_ifu #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem           (mif),
        .jump_en_in    (jump_en),
        .jump_addr_in  (jump_addr),
        .hold_en_in    (hold_en),
        .inst_valid_out(inst_valid),
        .inst_out      (inst),
        .inst_addr_out (inst_addr),
        .dbg_state_o   (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Memory model: accepted addresses queue up and return (addr ^ K) in order after mem_lat cycles.
    logic [31:0] pend_q[$];
    int          due_q[$];
    int          cyc = 0;
    int          mem_lat = 1;
    bit          mem_stall = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            pend_q.delete();
            due_q.delete();
        end else if (mif.mem_req_valid_out && mif.mem_req_ready_in) begin
            pend_q.push_back(mif.mem_req_addr_out);
            due_q.push_back(cyc + mem_lat);
        end
    end

    initial begin
        mif.mem_rsp_valid_in = 1'b0;
        mif.mem_rsp_data_in  = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (!mem_stall && pend_q.size() > 0 && due_q[0] <= cyc) begin
                mif.mem_rsp_valid_in = 1'b1;
                mif.mem_rsp_data_in  = pend_q.pop_front() ^ K;
                void'(due_q.pop_front());
            end else begin
                mif.mem_rsp_valid_in = 1'b0;
                mif.mem_rsp_data_in  = 32'hDEAD_BEEF;
            end
        end
    end

    // Scoreboard: every dequeued instruction must be the next word of the current program path.
    logic [31:0] exp_next = 32'h0;
    bit          sb_en = 1'b0;
    int          n_deq = 0;
    int          rsp_count = 0;
    int          hold_hs = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (mif.mem_rsp_valid_in) rsp_count++;
            if (hold_en && mif.mem_req_valid_out && mif.mem_req_ready_in) hold_hs++;
            if (sb_en && inst_valid && !hold_en) begin
                chk("sb_addr", inst_addr, exp_next);
                chk("sb_inst", inst, exp_next ^ K);
                exp_next = exp_next + 32'd4;
                n_deq++;
            end
            if (jump_en) exp_next = {jump_addr[31:2], 2'b00};
        end
    end

    typedef struct {
        logic [31:0] target;
        logic [31:0] exp_req;
        logic [31:0] exp_next_req;
    } redir_t;

    redir_t tbl[3];
    bit     ok;
    int     mark;

    initial begin
        tbl[0] = '{32'h0000_0102, 32'h0000_0100, 32'h0000_0104};
        tbl[1] = '{32'h0000_1237, 32'h0000_1234, 32'h0000_1238};
        tbl[2] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000};

        rst = 1'b1;
        jump_en = 1'b0;
        jump_addr = 32'h0;
        hold_en = 1'b0;
        mif.mem_req_ready_in = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        sb_en = 1'b1;

        sample();
        chk("boot_state", 32'(dbg_state), 32'd0);
        chk("boot_req_valid", 32'(mif.mem_req_valid_out), 32'd0);
        chk("boot_req_addr", mif.mem_req_addr_out, 32'h0);
        chk("boot_inst_valid", 32'(inst_valid), 32'd0);
        chk("boot_inst", inst, NOP);
        chk("boot_inst_addr", inst_addr, 32'h0);

        step(); sample();
        chk("c1_state", 32'(dbg_state), 32'd1);
        chk("c1_req_valid", 32'(mif.mem_req_valid_out), 32'd1);
        chk("c1_req_addr", mif.mem_req_addr_out, 32'h0);
        chk("c1_inst_valid", 32'(inst_valid), 32'd0);

        step(); sample();
        chk("c2_req_addr", mif.mem_req_addr_out, 32'h4);
        chk("c2_inst_valid", 32'(inst_valid), 32'(BYP));
        chk("c2_inst", inst, BYP ? K : NOP);
        chk("c2_inst_addr", inst_addr, 32'h0);

        step(); mif.mem_req_ready_in = 1'b0; sample();
        chk("c3_inst_valid", 32'(inst_valid), 32'd1);
        chk("c3_inst_addr", inst_addr, BYP ? 32'h4 : 32'h0);
        chk("c3_req_valid", 32'(mif.mem_req_valid_out), 32'd1);
        chk("c3_req_addr", mif.mem_req_addr_out, 32'h8);
        for (int i = 0; i < 2; i++) begin
            step(); sample();
            chk("stall_req_valid", 32'(mif.mem_req_valid_out), 32'd1);
            chk("stall_req_addr", mif.mem_req_addr_out, 32'h8);
        end
        step(); mif.mem_req_ready_in = 1'b1; sample();
        chk("unstall_req_addr", mif.mem_req_addr_out, 32'h8);
        step(); sample();
        chk("after_stall_addr", mif.mem_req_addr_out, 32'hC);

        repeat (4) step();
        for (int i = 0; i < 8; i++) begin
            sample();
            chk("thru_valid", 32'(inst_valid), 32'd1);
            step();
        end

        hold_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sample();
            chk("hold_valid", 32'(inst_valid), 32'd1);
            step();
        end
        hold_en = 1'b0;
        chk("hold_req_bound", 32'(hold_hs <= 2), 32'd1);

        // Redirect with two requests still outstanding at the memory.
        repeat (3) step();
        mem_stall = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sample(); #1;
            if (pend_q.size() == 2) begin ok = 1'b1; break; end
            step();
        end
        chk("out2_reached", 32'(ok), 32'd1);
        step(); jump_en = 1'b1; jump_addr = 32'h0000_0102;
        sample();
        step(); jump_en = 1'b0; mem_stall = 1'b0; mark = rsp_count;
        sample();
        chk("j2_drain_state", 32'(dbg_state), 32'd2);
        chk("j2_no_req", 32'(mif.mem_req_valid_out), 32'd0);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(); sample();
            if (mif.mem_req_valid_out) begin ok = 1'b1; break; end
        end
        chk("j2_req_seen", 32'(ok), 32'd1);
        chk("j2_req_addr", mif.mem_req_addr_out, 32'h0000_0100);
        chk("j2_drops_before_req", 32'((rsp_count - mark) >= 2), 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(); sample();
            if (inst_valid) begin ok = 1'b1; break; end
        end
        chk("j2_out_seen", 32'(ok), 32'd1);
        chk("j2_first_addr", inst_addr, 32'h0000_0100);

        // Redirect in the same cycle as a request handshake and a response.
        repeat (4) step();
        jump_en = 1'b1; jump_addr = 32'h0000_0400;
        sample();
        chk("jhr_hs", 32'(mif.mem_req_valid_out && mif.mem_req_ready_in), 32'd1);
        chk("jhr_rsp", 32'(mif.mem_rsp_valid_in), 32'd1);
        step(); jump_en = 1'b0; sample();
        chk("jhr_drain_state", 32'(dbg_state), 32'd2);
        chk("jhr_no_req", 32'(mif.mem_req_valid_out), 32'd0);
        chk("jhr_no_stale", 32'(inst_valid), 32'd0);
        step(); sample();
        chk("jhr_req_valid", 32'(mif.mem_req_valid_out), 32'd1);
        chk("jhr_req_addr", mif.mem_req_addr_out, 32'h0000_0400);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(); sample();
            if (inst_valid) begin ok = 1'b1; break; end
        end
        chk("jhr_out_seen", 32'(ok), 32'd1);
        chk("jhr_first_addr", inst_addr, 32'h0000_0400);

        // Zero-outstanding redirects: request to the target the cycle after the jump.
        for (int t = 0; t < 3; t++) begin
            step(); mif.mem_req_ready_in = 1'b0;
            repeat (4) step();
            jump_en = 1'b1; jump_addr = tbl[t].target;
            sample();
            step(); jump_en = 1'b0; mif.mem_req_ready_in = 1'b1;
            sample();
            chk("rd_req_valid", 32'(mif.mem_req_valid_out), 32'd1);
            chk("rd_req_addr", mif.mem_req_addr_out, tbl[t].exp_req);
            step(); sample();
            chk("rd_next_addr", mif.mem_req_addr_out, tbl[t].exp_next_req);
        end

        repeat (10) step();
        chk("deq_progress", 32'(n_deq >= 20), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        n_errors++;
        $display("FAIL watchdog: actual timeout required finish");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end
endmodule
